sigrok_byte_tx: RTL and testbench
=================================

// Module: sigrok_byte_tx
// PURPOSE
//   Serialises parallel words onto an sda/sck pair for capture by a sigrok logic analyser.
//   Sits downstream of the button/control logic, which presents words via a valid/ready handshake.
//   Generates its own sck from clk, so no separate clk_div instance is needed.
//   Framing is SPI-like: sck idles low, sda changes while sck is low, and data is stable on every sck rise.
// PARAMETERS
//   CLK_DIV   6   clk cycles per sck half-period; legal range >=1
//   DATA_W    8   bits per frame; legal range >=1
//   MSB_FIRST 1   1: shift tx_data[DATA_W-1] first; 0: shift tx_data[0] first
//   GAP       2   idle sck half-periods after each frame, sda=0 and sck=0; legal range >=0
// PORTS
//   clk       in   1       system clock
//   rst       in   1       asynchronous, active-high reset
//   tx_data   in   DATA_W  word to send; sampled only on a handshake
//   tx_valid  in   1       upstream has a word
//   tx_ready  out  1       block can accept a word (combinational: state==IDLE)
//   busy      out  1       frame or gap in progress (state!=IDLE)
//   sda       out  1       serial data, registered
//   sck       out  1       serial clock, registered
// BEHAVIOUR
//   Reset
//   - rst asserted puts the block in IDLE immediately, at any time.
//   - While reset is held: sda=0, sck=0, busy=0, tx_ready=1, shift register and counters cleared.
//   - Reset during SHIFT or GAP abandons the frame. No partial-frame recovery.
//   States: IDLE -> SHIFT -> GAP -> IDLE. If GAP=0, SHIFT goes directly to IDLE.
//   IDLE
//   - A handshake occurs on a clk edge with tx_valid=1 and tx_ready=1.
//   - Effects: capture tx_data into the shift register; go to SHIFT; half-period counter hc=0; bit counter bc=0.
//   - On the same edge, sda is set to the first bit and sck stays 0.
//   SHIFT
//   - hc counts 0..CLK_DIV-1. At hc=CLK_DIV-1, hc wraps to 0 and sck toggles.
//   - On sck 0->1: no sda change.
//   - On sck 1->0 with bc<DATA_W-1: bc++ and sda takes the next bit, on the same edge.
//   - On sck 1->0 with bc=DATA_W-1: sda=0 and go to GAP (or IDLE if GAP=0).
//   - The frame is exactly DATA_W sck rises, and 2*DATA_W*CLK_DIV clk cycles from handshake to exit.
//   GAP
//   - Hold sda=0 and sck=0 for GAP*CLK_DIV clk cycles, then go to IDLE.
//   Handshake rules
//   - tx_ready=0 in SHIFT and GAP. tx_valid is ignored there, and tx_data changes there do not affect the frame.
//   - Back-to-back: a word held valid is accepted on the first IDLE cycle.
//   - Minimum word period is (2*DATA_W+GAP)*CLK_DIV+1 clk cycles.
//   - tx_valid may deassert without a handshake; no state change results.
//   Widths
//   - hc is $clog2(CLK_DIV+1) bits; bc is $clog2(DATA_W+1) bits; the GAP counter is sized for GAP*CLK_DIV.
//   - No counter may overflow at legal parameter values.
//   CLK_DIV=1: sck toggles every clk; sda changes on the same edge as each sck fall.
// TESTING
//   1 Reset: rst=1 with tx_valid=1 -> sda=0, sck=0, tx_ready=1, busy=0. No frame starts until rst=0.
//   2 CLK_DIV=2, MSB_FIRST=1, 0xA5
//     - Sampled on sck rises, sda = 1,0,1,0,0,1,0,1.
//     - Exactly 8 rises; busy high for 32+4 clks; then tx_ready=1.
//   3 MSB_FIRST=0, 0x01 -> sda = 1,0,0,0,0,0,0,0 on the rises.
//     - Change tx_data to 0xFF mid-frame -> no effect on the frame.
//   4 Back-to-back: tx_valid held with 0x3C then 0xC3
//     - Two handshakes, (16+2)*6+1 clks apart at defaults.
//     - sda=0 and sck=0 throughout the gap.
//   5 Reset pulse after the 3rd sck rise of a frame
//     - Same clk: sda=0, sck=0, busy=0.
//     - The next frame after release is complete and correct.
//   6 CLK_DIV=1, GAP=0, 0xFF: sck toggles every clk, 16 clks per frame, sda=1 on all 8 rises.

Source files
------------

// File: rtl/sigrok_byte_tx.sv
// Serialises parallel words onto an SPI-like sda/sck pair for a sigrok logic analyser.
// sck idles low, sda changes only while sck is low, and each frame is followed by an idle gap.
module sigrok_byte_tx #(
  parameter int CLK_DIV   = 6,
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              sda,
  output logic              sck
);

  localparam int HW      = $clog2(CLK_DIV + 1);
  localparam int BW      = $clog2(DATA_W + 1);
  localparam int GAP_CYC = GAP * CLK_DIV;
  localparam int GW      = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [HW-1:0] HC_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GC_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n, shreg_adv;
  logic [HW-1:0]     hc, hc_n;
  logic [BW-1:0]     bc, bc_n;
  logic [GW-1:0]     gc, gc_n;
  logic              sda_n, sck_n;

  assign tx_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign shreg_adv = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      shreg <= '0;
      hc    <= '0;
      bc    <= '0;
      gc    <= '0;
      sda   <= 1'b0;
      sck   <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      hc    <= hc_n;
      bc    <= bc_n;
      gc    <= gc_n;
      sda   <= sda_n;
      sck   <= sck_n;
    end
  end

  // The bit to present next always sits at the outgoing end of the shift register.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    hc_n    = hc;
    bc_n    = bc;
    gc_n    = gc;
    sda_n   = sda;
    sck_n   = sck;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          shreg_n = tx_data;
          sda_n   = (MSB_FIRST != 0) ? tx_data[DATA_W-1] : tx_data[0];
          sck_n   = 1'b0;
          hc_n    = '0;
          bc_n    = '0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (hc == HC_LAST) begin
          hc_n  = '0;
          sck_n = ~sck;
          if (sck) begin
            if (bc == BC_LAST) begin
              sda_n   = 1'b0;
              gc_n    = '0;
              state_n = (GAP_CYC > 0) ? S_GAP : S_IDLE;
            end else begin
              bc_n    = bc + 1'b1;
              shreg_n = shreg_adv;
              sda_n   = (MSB_FIRST != 0) ? shreg_adv[DATA_W-1] : shreg_adv[0];
            end
          end
        end else begin
          hc_n = hc + 1'b1;
        end
      end
      S_GAP: begin
        if (gc == GC_LAST) begin
          state_n = S_IDLE;
        end else begin
          gc_n = gc + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sigrok_byte_tx.sv
// Self-checking bench for sigrok_byte_tx: four instances with different parameters,
// directed and random frames checked against a bit-order/timing model derived from the framing rules.
module tb_sigrok_byte_tx;

  localparam int CDIV [4] = '{2, 2, 6, 1};
  localparam int MSBV [4] = '{1, 0, 1, 1};
  localparam int GAPV [4] = '{2, 2, 2, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       busy     [4];
  logic       sda      [4];
  logic       sck      [4];

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          hs_cnt    [4] = '{default: 0};
  int          last_hs   [4] = '{default: 0};
  int          prev_hs   [4] = '{default: 0};
  int          rise_cnt  [4] = '{default: 0};
  int          busy_cnt  [4] = '{default: 0};
  int          viol      [4] = '{default: 0};
  int          fr        [4] = '{default: 0};
  logic [31:0] rise_word [4] = '{default: 32'h0};
  logic        prev_sck  [4] = '{default: 1'b0};
  logic        prev_sda  [4] = '{default: 1'b0};

  always #5 clk = ~clk;

  sigrok_byte_tx #(.CLK_DIV(2), .DATA_W(8), .MSB_FIRST(1), .GAP(2)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .busy(busy[0]), .sda(sda[0]), .sck(sck[0]));
  sigrok_byte_tx #(.CLK_DIV(2), .DATA_W(8), .MSB_FIRST(0), .GAP(2)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .busy(busy[1]), .sda(sda[1]), .sck(sck[1]));
  sigrok_byte_tx #(.CLK_DIV(6), .DATA_W(8), .MSB_FIRST(1), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .busy(busy[2]), .sda(sda[2]), .sck(sck[2]));
  sigrok_byte_tx #(.CLK_DIV(1), .DATA_W(8), .MSB_FIRST(1), .GAP(0)) dut3 (
    .clk(clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .busy(busy[3]), .sda(sda[3]), .sck(sck[3]));

  // Handshakes are recorded at the edge where they happen.
  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < 4; u++) begin
      if (!rst && tx_valid[u] && tx_ready[u]) begin
        prev_hs[u] = last_hs[u];
        last_hs[u] = cyc;
        hs_cnt[u]++;
      end
    end
  end

  // Line monitor: captures sda on each sck rise and counts framing-rule violations.
  always @(negedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (sck[u] && !prev_sck[u]) begin
        rise_cnt[u]++;
        fr[u]++;
        rise_word[u] = {rise_word[u][30:0], sda[u]};
      end
      if (sck[u] && prev_sck[u] && (sda[u] !== prev_sda[u])) viol[u]++;
      if (busy[u] === tx_ready[u]) viol[u]++;
      if (!busy[u] && (sda[u] || sck[u])) viol[u]++;
      if (busy[u] && fr[u] >= 8 && !sck[u] && sda[u]) viol[u]++;
      if (fr[u] > 8) viol[u]++;
      if (busy[u]) busy_cnt[u]++;
      else fr[u] = 0;
      prev_sck[u] = sck[u];
      prev_sda[u] = sda[u];
    end
  end

  function automatic logic [7:0] exp_bits(input int u, input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = (MSBV[u] != 0) ? w[7-i] : w[i];
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hs(input int u);
    int h0;
    logic ok;
    h0 = hs_cnt[u];
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (hs_cnt[u] != h0) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("hs_wait%0d", u), {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input int u);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (!busy[u]) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("idle_wait%0d", u), {31'd0, ok}, 32'd1);
  endtask

  task automatic apply_stimulus(input int u, input logic [7:0] w, input logic [7:0] upd);
    step();
    tx_data[u]  = w;
    tx_valid[u] = 1'b1;
    wait_hs(u);
    tx_valid[u] = 1'b0;
    tx_data[u]  = upd;
  endtask

  task automatic check_output(input int u, input logic [7:0] w, input int r0, input int b0, input int v0);
    chk($sformatf("rises%0d", u), rise_cnt[u] - r0, 32'd8);
    chk($sformatf("bits%0d_%02h", u, w), {24'd0, rise_word[u][7:0]}, {24'd0, exp_bits(u, w)});
    chk($sformatf("busy_clks%0d", u), busy_cnt[u] - b0, (16 + GAPV[u]) * CDIV[u]);
    chk($sformatf("protocol%0d", u), viol[u] - v0, 32'd0);
    chk($sformatf("ready_after%0d", u), {31'd0, tx_ready[u]}, 32'd1);
  endtask

  task automatic send(input int u, input logic [7:0] w, input logic [7:0] upd);
    int r0, b0, v0;
    r0 = rise_cnt[u];
    b0 = busy_cnt[u];
    v0 = viol[u];
    apply_stimulus(u, w, upd);
    wait_idle(u);
    check_output(u, w, r0, b0, v0);
  endtask

  initial begin
    int r0, b0, v0, u;
    logic ok;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_valid[k] = 1'b1;
      tx_data[k]  = 8'hA5;
    end

    // Reset held with valid asserted: everything quiet, no frame starts.
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_sda%0d", k), {31'd0, sda[k]}, 32'd0);
      chk($sformatf("rst_sck%0d", k), {31'd0, sck[k]}, 32'd0);
      chk($sformatf("rst_ready%0d", k), {31'd0, tx_ready[k]}, 32'd1);
      chk($sformatf("rst_busy%0d", k), {31'd0, busy[k]}, 32'd0);
    end
    for (int k = 0; k < 4; k++) tx_valid[k] = 1'b0;
    step();
    rst = 1'b0;
    repeat (2) step();
    $display("[TB] reset checks done");

    send(0, 8'hA5, 8'h00);
    send(1, 8'h01, 8'hFF);

    // Back-to-back words with valid held on the default-parameter instance.
    r0 = rise_cnt[2];
    b0 = busy_cnt[2];
    v0 = viol[2];
    step();
    tx_data[2]  = 8'h3C;
    tx_valid[2] = 1'b1;
    wait_hs(2);
    tx_data[2] = 8'hC3;
    wait_hs(2);
    tx_valid[2] = 1'b0;
    tx_data[2]  = 8'h00;
    wait_idle(2);
    chk("b2b_period", last_hs[2] - prev_hs[2], 32'd109);
    chk("b2b_rises", rise_cnt[2] - r0, 32'd16);
    chk("b2b_bits", {16'd0, rise_word[2][15:0]}, 32'h3CC3);
    chk("b2b_busy", busy_cnt[2] - b0, 32'd216);
    chk("b2b_protocol", viol[2] - v0, 32'd0);

    // Reset pulse right after the third sck rise abandons the frame.
    r0 = rise_cnt[0];
    step();
    tx_data[0]  = 8'h5A;
    tx_valid[0] = 1'b1;
    wait_hs(0);
    tx_valid[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rise_cnt[0] - r0 >= 3) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("third_rise_wait", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_sda", {31'd0, sda[0]}, 32'd0);
    chk("midrst_sck", {31'd0, sck[0]}, 32'd0);
    chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
    chk("midrst_ready", {31'd0, tx_ready[0]}, 32'd1);
    step();
    rst = 1'b0;
    send(0, 8'h96, 8'h69);

    send(3, 8'hFF, 8'h00);

    // Random words across the fast instances.
    for (int i = 0; i < 9; i++) begin
      u = (i % 3 == 2) ? 3 : (i % 3);
      send(u, 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
